// File: rtl/chip_host_driver.sv
// Host-side sequencer for the matrix-ALU chip: streams X operand bytes in, fires start,
// waits for ALU_done, then reads every result word back over the read_n/ry handshake.
module chip_host_driver #(
   parameter int N_LOAD    = 64,
   parameter int N_RESULTS = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       abort,
   input  logic       x_in_valid,
   input  logic [7:0] x_in_data,
   output logic       x_in_ready,
   output logic       valid_input,
   output logic [7:0] X_load,
   output logic       start_in,
   input  logic       ALU_done,
   output logic       read_n,
   output logic [7:0] r_addr,
   input  logic       ry,
   input  logic [8:0] read_data,
   output logic       res_valid,
   output logic [7:0] res_addr,
   output logic [8:0] res_data,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int BCW = $clog2(N_LOAD + 1);
   localparam int TCW = $clog2(TIMEOUT);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(N_LOAD - 1);
   localparam logic [7:0]     LAST_ADDR = 8'(N_RESULTS - 1);
   localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, READ_REQ, READ_GAP, FINISH} state_t;

   state_t         state, state_nxt;
   logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
   logic [7:0]     addr, addr_nxt;
   logic [TCW-1:0] tmr, tmr_nxt;
   logic           x_in_ready_nxt, valid_input_nxt, start_in_nxt, read_n_nxt;
   logic           res_valid_nxt, busy_nxt, done_nxt, err_nxt;
   logic [7:0]     x_load_nxt, r_addr_nxt, res_addr_nxt;
   logic [8:0]     res_data_nxt;
   logic           accept, capture, tmo;

   assign accept  = (state == LOAD) && x_in_valid && x_in_ready;
   assign capture = (state == READ_REQ) && !read_n && ry;
   assign tmo     = (tmr == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         addr        <= '0;
         tmr         <= '0;
         x_in_ready  <= 1'b0;
         valid_input <= 1'b0;
         X_load      <= '0;
         start_in    <= 1'b0;
         read_n      <= 1'b1;
         r_addr      <= '0;
         res_valid   <= 1'b0;
         res_addr    <= '0;
         res_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         byte_cnt    <= byte_cnt_nxt;
         addr        <= addr_nxt;
         tmr         <= tmr_nxt;
         x_in_ready  <= x_in_ready_nxt;
         valid_input <= valid_input_nxt;
         X_load      <= x_load_nxt;
         start_in    <= start_in_nxt;
         read_n      <= read_n_nxt;
         r_addr      <= r_addr_nxt;
         res_valid   <= res_valid_nxt;
         res_addr    <= res_addr_nxt;
         res_data    <= res_data_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
      end
   end

   // abort has priority over every transition, including go in IDLE
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      if (go) state_nxt = LOAD;
            LOAD:      if (accept && byte_cnt == LAST_BYTE) state_nxt = START;
            START:     state_nxt = WAIT_DONE;
            WAIT_DONE: begin
               if (ALU_done) state_nxt = READ_REQ;
               else if (tmo) state_nxt = IDLE;
            end
            READ_REQ:  begin
               if (capture) state_nxt = (addr == LAST_ADDR) ? FINISH : READ_GAP;
               else if (tmo) state_nxt = IDLE;
            end
            READ_GAP:  state_nxt = READ_REQ;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      byte_cnt_nxt    = byte_cnt;
      addr_nxt        = addr;
      tmr_nxt         = tmr;
      x_load_nxt      = X_load;
      res_addr_nxt    = res_addr;
      res_data_nxt    = res_data;
      err_nxt         = err;
      valid_input_nxt = 1'b0;
      start_in_nxt    = 1'b0;
      res_valid_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (go && !abort) begin
               byte_cnt_nxt = '0;
               addr_nxt     = '0;
               tmr_nxt      = '0;
               err_nxt      = 1'b0;
            end
         end
         LOAD: begin
            if (accept) begin
               valid_input_nxt = 1'b1;
               x_load_nxt      = x_in_data;
               byte_cnt_nxt    = byte_cnt + 1'b1;
            end
         end
         START: start_in_nxt = 1'b1;
         WAIT_DONE: begin
            if (ALU_done) begin
               tmr_nxt  = '0;
               addr_nxt = '0;
            end else if (tmo) begin
               err_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         READ_REQ: begin
            if (capture) begin
               res_valid_nxt = 1'b1;
               res_data_nxt  = read_data;
               res_addr_nxt  = addr;
               tmr_nxt       = '0;
               if (addr != LAST_ADDR) addr_nxt = addr + 8'd1;
            end else if (tmo) begin
               err_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         default: ;
      endcase
      // abort returns the chip side to its reset image and leaves err alone
      if (abort) begin
         valid_input_nxt = 1'b0;
         x_load_nxt      = '0;
         start_in_nxt    = 1'b0;
         res_valid_nxt   = 1'b0;
         err_nxt         = err;
      end
      x_in_ready_nxt = (state_nxt == LOAD);
      read_n_nxt     = (state_nxt != READ_REQ);
      r_addr_nxt     = (state_nxt == READ_REQ) ? addr_nxt : (abort ? 8'd0 : r_addr);
      busy_nxt       = state_nxt inside {LOAD, START, WAIT_DONE, READ_REQ, READ_GAP};
      done_nxt       = (state_nxt == FINISH);
   end
endmodule

// File: tb/tb_chip_host_driver.sv
// Directed bench for chip_host_driver with a small behavioural chip model
// (ALU_done after a fixed delay, ry after a programmable per-request delay).
module tb_chip_host_driver;
   logic       clk = 1'b0;
   logic       rst, go, abort, x_in_valid, ALU_done, ry;
   logic [7:0] x_in_data;
   logic [8:0] read_data;
   logic       x_in_ready, valid_input, start_in, read_n, res_valid, busy, done, err;
   logic [7:0] X_load, r_addr, res_addr;
   logic [8:0] res_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] src_tab [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [8:0] mem_tab [2] = '{9'h1AB, 9'h055};

   bit gapped, alu_en, alu_arm, phase, src_on;
   int src_idx, alu_wait, ry_wait, ry_dly;
   localparam int ALU_DLY = 5;

   // event log filled on the falling edge
   int cyc, vi_cnt, first_vi, last_vi, st_cnt, st_cyc, rv_cnt, rv0_cnt, done_cnt;
   int req_cnt, raddr_chg, low0_run, low0_max, err_cyc;
   logic [7:0] vi_log [8];
   logic [7:0] ra_log [8];
   logic [8:0] rd_log [8];
   logic       prev_read_n, prev_err;
   logic [7:0] prev_raddr;

   chip_host_driver #(.N_LOAD(4), .N_RESULTS(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort),
      .x_in_valid(x_in_valid), .x_in_data(x_in_data), .x_in_ready(x_in_ready),
      .valid_input(valid_input), .X_load(X_load), .start_in(start_in),
      .ALU_done(ALU_done), .read_n(read_n), .r_addr(r_addr), .ry(ry),
      .read_data(read_data), .res_valid(res_valid), .res_addr(res_addr),
      .res_data(res_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (valid_input) begin
         if (vi_cnt < 8) vi_log[vi_cnt] = X_load;
         if (vi_cnt == 0) first_vi = cyc;
         last_vi = cyc;
         vi_cnt++;
      end
      if (start_in) begin
         st_cnt++;
         st_cyc = cyc;
      end
      if (res_valid) begin
         if (rv_cnt < 8) begin
            ra_log[rv_cnt] = res_addr;
            rd_log[rv_cnt] = res_data;
         end
         rv_cnt++;
         if (res_addr == 8'd0) rv0_cnt++;
      end
      if (done) done_cnt++;
      if (!read_n && prev_read_n) req_cnt++;
      if (!read_n && !prev_read_n && r_addr != prev_raddr) raddr_chg++;
      if (!read_n && r_addr == 8'd0) begin
         low0_run++;
         if (low0_run > low0_max) low0_max = low0_run;
      end else begin
         low0_run = 0;
      end
      if (err && !prev_err) err_cyc = cyc;
      prev_read_n = read_n;
      prev_raddr  = r_addr;
      prev_err    = err;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      vi_cnt = 0; first_vi = 0; last_vi = 0; st_cnt = 0; st_cyc = 0;
      rv_cnt = 0; rv0_cnt = 0; done_cnt = 0; req_cnt = 0; raddr_chg = 0;
      low0_run = 0; low0_max = 0; err_cyc = 0;
   endtask

   // one clock: the source and chip model react to the registered outputs just after the edge
   task automatic tick();
      bit acc;
      acc = x_in_valid && x_in_ready;
      @(posedge clk);
      #1;
      if (acc) src_idx++;
      phase      = !phase;
      x_in_valid = src_on && (src_idx < 6) && (!gapped || phase);
      x_in_data  = (src_idx < 6) ? src_tab[src_idx] : 8'h00;
      if (start_in) begin
         alu_arm  = 1'b1;
         alu_wait = 0;
      end else if (alu_arm) begin
         alu_wait++;
      end
      ALU_done = alu_en && alu_arm && (alu_wait >= ALU_DLY);
      if (!read_n) begin
         if (ry_wait >= ry_dly) begin
            ry        = 1'b1;
            read_data = mem_tab[r_addr[0]];
         end else begin
            ry = 1'b0;
            ry_wait++;
         end
      end else begin
         ry        = 1'b0;
         read_data = '0;
         ry_wait   = 0;
      end
   endtask

   task automatic start_run(input bit gap, input bit alu_on, input int rdly);
      gapped = gap; alu_en = alu_on; ry_dly = rdly;
      alu_arm = 1'b0; alu_wait = 0; ALU_done = 1'b0; ry_wait = 0;
      src_idx = 0; phase = 1'b1; src_on = 1'b1;
      x_in_valid = 1'b1; x_in_data = src_tab[0];
      clear_log();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic finish_run(input string tag, input int extra_go);
      int n = 0;
      while (busy && n < 200) begin
         if (n == extra_go) go = 1'b1;
         tick();
         go = 1'b0;
         n++;
      end
      check_eq({tag, "_bound"}, 32'(n < 200), 32'd1);
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; go = 1'b0; abort = 1'b0; x_in_valid = 1'b0; x_in_data = '0;
      ALU_done = 1'b0; ry = 1'b0; read_data = '0; src_on = 1'b0; gapped = 1'b0;
      alu_en = 1'b0; alu_arm = 1'b0; phase = 1'b0; src_idx = 0; ry_dly = 0;
      prev_read_n = 1'b1; prev_err = 1'b0; prev_raddr = '0; cyc = 0;
      clear_log();
      #12;
      check_eq("rst_read_n", 32'(read_n), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(x_in_ready), 32'd0);
      check_eq("rst_vi", 32'(valid_input), 32'd0);
      check_eq("rst_raddr", 32'(r_addr), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_done_start", 32'({done, start_in, res_valid}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // abort beats go in IDLE
      abort = 1'b1; go = 1'b1;
      tick();
      abort = 1'b0; go = 1'b0;
      check_eq("abortgo_busy", 32'(busy), 32'd0);
      check_eq("abortgo_ready", 32'(x_in_ready), 32'd0);

      // basic back-to-back run
      start_run(1'b0, 1'b1, 0);
      check_eq("basic_busy", 32'(busy), 32'd1);
      finish_run("basic", -1);
      check_eq("basic_vi_cnt", 32'(vi_cnt), 32'd4);
      check_eq("basic_x0", 32'(vi_log[0]), 32'h11);
      check_eq("basic_x1", 32'(vi_log[1]), 32'h22);
      check_eq("basic_x2", 32'(vi_log[2]), 32'h33);
      check_eq("basic_x3", 32'(vi_log[3]), 32'h44);
      check_eq("basic_vi_span", 32'(last_vi - first_vi), 32'd3);
      check_eq("basic_start_cnt", 32'(st_cnt), 32'd1);
      check_eq("basic_start_pos", 32'(st_cyc - last_vi), 32'd1);
      check_eq("basic_accepted", 32'(src_idx), 32'd4);
      check_eq("basic_req_cnt", 32'(req_cnt), 32'd2);
      check_eq("basic_rv_cnt", 32'(rv_cnt), 32'd2);
      check_eq("basic_ra0", 32'(ra_log[0]), 32'd0);
      check_eq("basic_rd0", 32'(rd_log[0]), 32'h1AB);
      check_eq("basic_ra1", 32'(ra_log[1]), 32'd1);
      check_eq("basic_rd1", 32'(rd_log[1]), 32'h055);
      check_eq("basic_done", 32'(done_cnt), 32'd1);
      check_eq("basic_err", 32'(err), 32'd0);

      // gapped stream, plus a go pulse while busy
      start_run(1'b1, 1'b1, 0);
      finish_run("gap", 3);
      check_eq("gap_vi_cnt", 32'(vi_cnt), 32'd4);
      check_eq("gap_vi_span", 32'(last_vi - first_vi), 32'd6);
      check_eq("gap_x3", 32'(vi_log[3]), 32'h44);
      check_eq("gap_accepted", 32'(src_idx), 32'd4);
      check_eq("gap_done", 32'(done_cnt), 32'd1);
      check_eq("gap_idle_after", 32'(busy), 32'd0);

      // slow ry on every request
      start_run(1'b0, 1'b1, 5);
      finish_run("rydly", -1);
      check_eq("rydly_hold", 32'(low0_max), 32'd6);
      check_eq("rydly_raddr_stable", 32'(raddr_chg), 32'd0);
      check_eq("rydly_rv0", 32'(rv0_cnt), 32'd1);
      check_eq("rydly_rd1", 32'(rd_log[1]), 32'h055);
      check_eq("rydly_done", 32'(done_cnt), 32'd1);

      // ALU_done never arrives
      start_run(1'b0, 1'b0, 0);
      finish_run("tmo", -1);
      check_eq("tmo_err", 32'(err), 32'd1);
      check_eq("tmo_wait_cycles", 32'(err_cyc - st_cyc), 32'd8);
      check_eq("tmo_done", 32'(done_cnt), 32'd0);
      check_eq("tmo_rv", 32'(rv_cnt), 32'd0);

      // next go clears err; abort while requesting addr 1
      start_run(1'b0, 1'b1, 3);
      check_eq("go_clears_err", 32'(err), 32'd0);
      n = 0;
      while (!(!read_n && r_addr == 8'd1) && n < 200) begin
         tick();
         n++;
      end
      check_eq("abort_reach_addr1", 32'(n < 200), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_read_n", 32'(read_n), 32'd1);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_raddr", 32'(r_addr), 32'd0);
      check_eq("abort_rv_now", 32'(res_valid), 32'd0);
      repeat (3) tick();
      check_eq("abort_rv_cnt", 32'(rv_cnt), 32'd1);
      check_eq("abort_done", 32'(done_cnt), 32'd0);
      check_eq("abort_err_kept", 32'(err), 32'd0);

      // asynchronous reset in the middle of LOAD
      start_run(1'b0, 1'b1, 0);
      tick();
      check_eq("arst_pre_vi", 32'(valid_input), 32'd1);
      check_eq("arst_pre_busy", 32'(busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_eq("arst_vi", 32'(valid_input), 32'd0);
      check_eq("arst_xload", 32'(X_load), 32'd0);
      check_eq("arst_ready", 32'(x_in_ready), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_read_n", 32'(read_n), 32'd1);
      #1;
      rst = 1'b0;
      src_on = 1'b0;
      x_in_valid = 1'b0;
      clear_log();
      repeat (3) tick();
      check_eq("arst_done", 32'(done_cnt), 32'd0);
      check_eq("arst_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
